// File: rtl/drive_mode_fsm.sv
// drive_mode_fsm: driving-mode controller for the simulated car.
// Turns debounced driver switches into movement commands for the UART packet
// builder, and drives the state code plus the indicator LEDs.
// Also provides a power-on hold time, a global power-off override, an idle
// auto-power-off, a turn-signal flasher and a saturating mileage counter.
//
// Ports:
//   sys_clk, rst                    clock; asynchronous active-low reset
//   power_on/off, manual_driving    driver controls
//   throttle, clutch, brake,
//   reverse                         pedals and gear
//   turn_left/right_signal          steering
//   state_o                         current state code
//   move_forward/backward,
//   turn_left/right                 movement commands (MOVING only)
//   left/right_turn_led,
//   reverse_led                     indicator LEDs
//   mileage                         saturating distance count, cleared by rst only
//
// state        | meaning
// -------------+----------------------------------------------------------
// OFF          | powered down; waiting for PWR_HOLD consecutive power_on samples
// ON           | powered, waiting for manual driving mode
// NOT_STARTING | manual mode, engine not turning; both turn LEDs lit
// STARTING     | clutch engaged, ready to move off
// MOVING       | car moving; movement commands are live
module drive_mode_fsm #(
  parameter int PWR_HOLD     = 100,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int FLASH_HALF   = 50,
  parameter int MILE_DIV     = 1000,
  parameter int MILE_W       = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              power_on_signal,
  input  logic              power_off_signal,
  input  logic              manual_driving_signal,
  input  logic              throttle_signal,
  input  logic              clutch_signal,
  input  logic              brake_signal,
  input  logic              reverse_signal,
  input  logic              turn_left_signal,
  input  logic              turn_right_signal,
  output logic [2:0]        state_o,
  output logic              move_forward,
  output logic              move_backward,
  output logic              turn_left,
  output logic              turn_right,
  output logic              left_turn_led,
  output logic              right_turn_led,
  output logic              reverse_led,
  output logic [MILE_W-1:0] mileage
);

  localparam logic [2:0] ST_OFF          = 3'd0;
  localparam logic [2:0] ST_ON           = 3'd1;
  localparam logic [2:0] ST_NOT_STARTING = 3'd2;
  localparam logic [2:0] ST_STARTING     = 3'd3;
  localparam logic [2:0] ST_MOVING       = 3'd4;

  localparam int PWR_W   = $clog2(PWR_HOLD + 1);
  localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 2);
  localparam int FLASH_W = $clog2(FLASH_HALF + 1);
  localparam int PRE_W   = $clog2(MILE_DIV + 1);

  localparam logic [PWR_W-1:0]   PWR_LAST   = PWR_W'(PWR_HOLD - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF - 1);
  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(MILE_DIV - 1);

  logic [2:0]         state, state_nxt;
  logic [PWR_W-1:0]   pwr_cnt, pwr_cnt_nxt;
  logic [IDLE_W-1:0]  idle_cnt, idle_cnt_nxt;
  logic [FLASH_W-1:0] flash_cnt;
  logic               flash;
  logic [PRE_W-1:0]   mile_pre;
  logic               reverse_d;
  logic               reverse_change;
  logic               idle_active, idle_quiet, idle_expire;
  logic [2:0]         pedals;

  assign pedals         = {throttle_signal, brake_signal, clutch_signal};
  assign reverse_change = reverse_signal ^ reverse_d;
  assign idle_active    = (state == ST_ON) || (state == ST_NOT_STARTING);
  assign idle_quiet     = ~(manual_driving_signal | throttle_signal |
                            clutch_signal | brake_signal);
  // IDLE_TIMEOUT of 0 disables the auto power-off entirely.
  assign idle_expire    = (IDLE_TIMEOUT != 0) && idle_active && idle_quiet &&
                          (idle_cnt == IDLE_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:
        if (power_on_signal && (pwr_cnt == PWR_LAST)) state_nxt = ST_ON;
      ST_ON:
        if (manual_driving_signal) state_nxt = ST_NOT_STARTING;
      ST_NOT_STARTING:
        if (pedals == 3'b101)      state_nxt = ST_STARTING;
        else if (pedals == 3'b100) state_nxt = ST_OFF;   // stall
      ST_STARTING:
        if (brake_signal)          state_nxt = ST_NOT_STARTING;
        else if (pedals == 3'b100) state_nxt = ST_MOVING;
      ST_MOVING:
        if (reverse_change && !clutch_signal)        state_nxt = ST_OFF;
        else if (brake_signal)                       state_nxt = ST_NOT_STARTING;
        else if (!throttle_signal || clutch_signal)  state_nxt = ST_STARTING;
      default:
        state_nxt = ST_OFF;
    endcase
    // Power-off and idle expiry override every state-specific rule.
    if ((state != ST_OFF) && (power_off_signal || idle_expire)) state_nxt = ST_OFF;
  end

  always_comb begin
    pwr_cnt_nxt = '0;
    if ((state == ST_OFF) && power_on_signal && (state_nxt == ST_OFF))
      pwr_cnt_nxt = pwr_cnt + PWR_W'(1);
  end

  always_comb begin
    idle_cnt_nxt = '0;
    if (idle_active && idle_quiet && (state_nxt == state))
      idle_cnt_nxt = idle_cnt + IDLE_W'(1);
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_OFF;
      pwr_cnt   <= '0;
      idle_cnt  <= '0;
      reverse_d <= 1'b0;
    end else begin
      state     <= state_nxt;
      pwr_cnt   <= pwr_cnt_nxt;
      idle_cnt  <= idle_cnt_nxt;
      reverse_d <= reverse_signal;
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      flash_cnt <= '0;
      flash     <= 1'b0;
    end else if (flash_cnt == FLASH_LAST) begin
      flash_cnt <= '0;
      flash     <= ~flash;
    end else begin
      flash_cnt <= flash_cnt + FLASH_W'(1);
    end
  end

  // Prescaler only advances in MOVING and keeps its phase otherwise,
  // so partial distance is not lost across stops.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      mile_pre <= '0;
      mileage  <= '0;
    end else if (state == ST_MOVING) begin
      if (mile_pre == PRE_LAST) begin
        mile_pre <= '0;
        if (mileage != {MILE_W{1'b1}}) mileage <= mileage + MILE_W'(1);
      end else begin
        mile_pre <= mile_pre + PRE_W'(1);
      end
    end
  end

  always_comb begin
    move_forward   = 1'b0;
    move_backward  = 1'b0;
    turn_left      = 1'b0;
    turn_right     = 1'b0;
    left_turn_led  = 1'b0;
    right_turn_led = 1'b0;
    reverse_led    = 1'b0;
    case (state)
      ST_NOT_STARTING: begin
        left_turn_led  = 1'b1;
        right_turn_led = 1'b1;
      end
      ST_STARTING:
        reverse_led = reverse_signal;
      ST_MOVING: begin
        move_forward   = ~reverse_signal;
        move_backward  = reverse_signal;
        turn_left      = turn_left_signal;
        turn_right     = turn_right_signal;
        left_turn_led  = turn_left_signal & ~turn_right_signal & flash;
        right_turn_led = turn_right_signal & ~turn_left_signal & flash;
        reverse_led    = reverse_signal;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: doc/drive_mode_fsm.md
# drive_mode_fsm

Parametrised driving-mode controller for the simulated car: next generation of the power/drive state machine. Converts debounced driver switches into movement commands for the UART packet builder, plus state and indicator LED outputs. Adds a configurable power-on hold time, a global power-off override, an idle auto-power-off timer, a parametrised turn-signal flash rate and a saturating mileage counter. Sits between the input synchronisers and the UART/segment-display blocks.

## Interface
- PWR_HOLD, 100, consecutive high cycles of power_on_signal required to power on (>=1)
- IDLE_TIMEOUT, 1000, idle cycles in ON/NOT_STARTING before auto power-off; 0 disables
- FLASH_HALF, 50, cycles per half-period of the turn flash (>=1)
- MILE_DIV, 1000, MOVING cycles per mileage increment (>=1)
- MILE_W, 16, mileage counter width
- sys_clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- power_on_signal, power_off_signal, manual_driving_signal  in  1 each  driver controls, synchronous to sys_clk
- throttle_signal, clutch_signal, brake_signal, reverse_signal  in  1 each  pedals/gear
- turn_left_signal, turn_right_signal  in  1 each  steering
- state_o  out  3  current state encoding
- move_forward, move_backward, turn_left, turn_right  out  1 each  movement commands
- left_turn_led, right_turn_led, reverse_led  out  1 each  indicators
- mileage  out  MILE_W  distance count

## Operation
- States: OFF=0, ON=1, NOT_STARTING=2, STARTING=3, MOVING=4; codes 5-7 go to OFF on the next edge.
- Priority in every non-OFF state: power_off_signal -> OFF; then idle timeout; then the state-specific rules below.
- OFF: power-on counter increments while power_on_signal=1 and clears on any 0. Leaves for ON when the PWR_HOLD-th consecutive high sample occurs. Counter is cleared in all other states.
- ON: manual_driving_signal -> NOT_STARTING; else stay.
- NOT_STARTING: {throttle,brake,clutch}=101 -> STARTING; 100 -> OFF (stall); else stay.
- STARTING: brake=1 -> NOT_STARTING; 100 -> MOVING; else stay.
- MOVING: reverse_change with clutch=0 -> OFF. Otherwise brake=1 -> NOT_STARTING; throttle=0 or clutch=1 -> STARTING; else stay.
- reverse_change: reverse_signal XOR its one-cycle-delayed register. The delay register resets to 0.
- Idle timer: active only in ON and NOT_STARTING. Increments when manual, throttle, clutch and brake are all 0; cleared by any of them high, or on state change. Reaching IDLE_TIMEOUT -> OFF.
- Movement outputs (combinational from state register and inputs): all 0 outside MOVING. In MOVING: forward=~reverse_signal, backward=reverse_signal, turn_left/right pass through.
- LEDs:
  - NOT_STARTING: both turn LEDs 1.
  - MOVING: only left asserted -> left LED = flash; only right asserted -> right LED = flash; otherwise both 0.
  - reverse_led = reverse_signal in STARTING/MOVING, else 0.
  - All LEDs 0 in other states.
- Flash: free-running counter. flash toggles every FLASH_HALF cycles from reset value 0.
- Mileage:
  - In MOVING, a prescaler counts 0..MILE_DIV-1. On wrap, mileage increments and saturates at 2^MILE_W-1.
  - Outside MOVING the prescaler holds its value; it is not cleared.
  - Mileage is cleared only by rst and persists across power-off.

## Timing
- Reset values: state OFF, all counters 0, flash 0, mileage 0. All movement/LED outputs are therefore 0 and state_o=0.
- State changes one edge after the qualifying input sample. Movement/LED outputs follow the state register combinationally, so they have zero added latency.
- Power-on: power_on_signal rising before edge k (high from edge k onward) gives state ON after edge k+PWR_HOLD-1.
- rst asserted mid-operation: immediate OFF, counters cleared, mileage cleared.
- Simultaneous power_off_signal and any transition condition: OFF wins.
- Simultaneous reverse_change (no clutch) and brake in MOVING: OFF wins.

## Test plan
- PWR_HOLD=4: power_on high 3 cycles, low 1, then high 4 -> stays OFF until the 4th consecutive high sample, then state_o=1.
- ON -> manual -> NOT_STARTING; throttle+clutch -> STARTING; release clutch -> MOVING with move_forward=1. Then brake -> NOT_STARTING and both turn LEDs 1.
- MOVING, toggle reverse with clutch=0 -> state_o=0 next edge, all outputs 0. Repeat with clutch=1 -> state STARTING (clutch rule), reverse_led=1.
- IDLE_TIMEOUT=8 in NOT_STARTING, no inputs -> OFF after 8 cycles. A brake pulse at cycle 5 restarts the count.
- MILE_DIV=3, MILE_W=2: 12 MOVING cycles -> mileage reaches 3 and holds. power_off then power on -> mileage still 3; rst -> 0.
- FLASH_HALF=2, MOVING with turn_left only -> left_turn_led pattern 0,0,1,1,0,0 and right_turn_led 0 throughout.
